calc_hist: RTL

Parametrised successor to the board-level accumulator calculator. It applies a 3-bit op, selected by {btnl,btnc,btnr}, to the accumulator and the switch operand on a btnd press. New over the previous generation:
- configurable WIDTH
- btnd/undo edge detection, so a held button fires exactly once
- a DEPTH-entry undo history
- an extended op set, including an iterative multi-cycle multiply with busy
- a signed/unsigned overflow flag

It sits between the board switches/buttons and the LEDs.

---
 rtl/calc_hist_if.sv | 30 +++
 rtl/calc_hist.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/calc_hist_if.sv
// Button/switch/LED bundle for the calc_hist accumulator calculator.
// The board side (switches, buttons, LEDs) is the master; the calculator is the slave.
interface calc_hist_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             btnd;
    logic             btnl;
    logic             btnc;
    logic             btnr;
    logic             undo;
    logic             ext;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] led;
    logic             ovf;
    logic             busy;
    logic [CW-1:0]    hist_cnt;

    modport master (
        output btnd, btnl, btnc, btnr, undo, ext, sw,
        input  led, ovf, busy, hist_cnt
    );

    modport slave (
        input  btnd, btnl, btnc, btnr, undo, ext, sw,
        output led, ovf, busy, hist_cnt
    );
endinterface

// File: rtl/calc_hist.sv
// Accumulator calculator with edge-detected buttons, an undo history ring,
// an extended op set and an iterative shift-add multiplier.
module calc_hist #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        btnu,
    calc_hist_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

    // Registered state
    logic                 r_btnd_q;
    logic                 r_undo_q;
    logic [WIDTH-1:0]     r_acc;
    logic                 r_ovf;
    logic                 r_busy;
    logic [CW-1:0]        r_cnt;
    logic [PW-1:0]        r_ptr;      // next slot to write
    logic [WIDTH-1:0]     r_hist [DEPTH];
    logic [2*WIDTH-1:0]   r_mul_a;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]     r_mul_b;    // multiplier, shifted right each step
    logic [2*WIDTH-1:0]   r_prod;
    logic [SW-1:0]        r_mul_cnt;

    // Combinational decode
    logic [2:0]           w_op;
    logic                 w_exe;
    logic                 w_und;
    logic                 w_start_mul;
    logic                 w_single;
    logic                 w_mul_last;
    logic                 w_push;
    logic [2*WIDTH-1:0]   w_mul_sum;
    logic [PW-1:0]        w_ptr_next;
    logic [PW-1:0]        w_ptr_prev;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [SW-1:0]        w_shamt;
    logic [WIDTH-1:0]     w_alu;
    logic                 w_alu_ovf;

    assign w_op        = {bus.btnl, bus.btnc, bus.btnr};
    // Presses during a multiply are dropped, and execute beats undo.
    assign w_exe       = bus.btnd & ~r_btnd_q & ~r_busy;
    assign w_und       = bus.undo & ~r_undo_q & ~r_busy & ~w_exe;
    assign w_start_mul = w_exe & bus.ext & (w_op == 3'b000);
    assign w_single    = w_exe & ~w_start_mul;
    assign w_mul_last  = r_busy && (r_mul_cnt == SW'(WIDTH - 1));
    assign w_mul_sum   = r_prod + (r_mul_b[0] ? r_mul_a : '0);
    assign w_push      = w_single | w_mul_last;
    assign w_ptr_next  = (r_ptr == LAST_SLOT) ? '0 : r_ptr + PW'(1);
    assign w_ptr_prev  = (r_ptr == '0) ? LAST_SLOT : r_ptr - PW'(1);
    assign w_sum       = r_acc + bus.sw;
    assign w_diff      = r_acc - bus.sw;
    assign w_shamt     = bus.sw[SW-1:0];

    // Single-cycle ALU result and overflow flag
    always_comb begin
        w_alu     = r_acc;
        w_alu_ovf = 1'b0;
        case (w_op)
            3'b000: begin
                w_alu     = w_sum;
                w_alu_ovf = (r_acc[WIDTH-1] == bus.sw[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
            end
            3'b001: begin
                if (bus.ext) begin
                    w_alu = ($signed(r_acc) < $signed(bus.sw)) ? WIDTH'(1) : '0;
                end else begin
                    w_alu     = w_diff;
                    w_alu_ovf = (r_acc[WIDTH-1] != bus.sw[WIDTH-1]) &&
                                (w_diff[WIDTH-1] != r_acc[WIDTH-1]);
                end
            end
            3'b010:  w_alu = r_acc & bus.sw;
            3'b011:  w_alu = r_acc | bus.sw;
            3'b100:  w_alu = r_acc ^ bus.sw;
            3'b101:  w_alu = r_acc << w_shamt;
            3'b110:  w_alu = r_acc >> w_shamt;
            default: w_alu = WIDTH'($signed(r_acc) >>> w_shamt);
        endcase
    end

    // Accumulator, multiplier sequencing, undo and history bookkeeping
    always_ff @(posedge clk) begin
        r_btnd_q <= bus.btnd;
        r_undo_q <= bus.undo;
        if (btnu) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_prod    <= '0;
            r_mul_cnt <= '0;
        end else begin
            if (w_start_mul) begin
                r_busy    <= 1'b1;
                r_mul_a   <= {{WIDTH{1'b0}}, r_acc};
                r_mul_b   <= bus.sw;
                r_prod    <= '0;
                r_mul_cnt <= '0;
            end else if (r_busy) begin
                r_prod    <= w_mul_sum;
                r_mul_a   <= r_mul_a << 1;
                r_mul_b   <= r_mul_b >> 1;
                r_mul_cnt <= r_mul_cnt + SW'(1);
                if (w_mul_last) begin
                    r_acc  <= w_mul_sum[WIDTH-1:0];
                    r_ovf  <= |w_mul_sum[2*WIDTH-1:WIDTH];
                    r_busy <= 1'b0;
                end
            end else if (w_single) begin
                r_acc <= w_alu;
                r_ovf <= w_alu_ovf;
            end else if (w_und && (r_cnt != '0)) begin
                r_acc <= r_hist[w_ptr_prev];
                r_ptr <= w_ptr_prev;
                r_cnt <= r_cnt - CW'(1);
                r_ovf <= 1'b0;
            end

            // A push never coincides with an undo, so these cannot conflict.
            if (w_push) begin
                r_ptr <= w_ptr_next;
                if (r_cnt != CW'(DEPTH)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // History ring write; acc is still the pre-op value at the push edge
    always_ff @(posedge clk) begin
        if (!btnu && w_push) begin
            r_hist[r_ptr] <= r_acc;
        end
    end

    assign bus.led      = r_acc;
    assign bus.ovf      = r_ovf;
    assign bus.busy     = r_busy;
    assign bus.hist_cnt = r_cnt;
endmodule
